cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run/step/halt sequencer for the minisys-32 core. Produces the single CPU
//  commit enable (cpu_en) gating PC update, register write and Data_mem write.
//  Handles free-run, single-step via confirm button, switch-input wait
//  (IORead stalls until confirm), a PC breakpoint and BREAK-instruction halt.
//  Sits between button debouncers / switches and IFetch / Decoder / Data_mem.
// PARAMETERS
//  ADDR_W   32   PC / breakpoint address width
//  CNT_W    32   retired-instruction counter width
//  BRK_FUNC 6'h0D  funct code that, with opcode 6'h00, is the halting BREAK
// PORTS
//  clock        in   1       system clock (CPU clock domain, clk1)
//  reset_n      in   1       synchronous reset, active-low
//  go_pulse     in   1       debounced confirm button, one-cycle pulse
//  mode_step    in   1       1 = single-step mode, 0 = free run (switch)
//  pc           in   ADDR_W  address of instruction currently presented
//  instruction  in   32      instruction currently presented by IFetch
//  io_read      in   1       Controller IORead for current instruction
//  bp_en        in   1       breakpoint enable
//  bp_addr      in   ADDR_W  breakpoint PC
//  cpu_en       out  1       commit enable; combinational (Mealy)
//  run_state    out  3       current state encoding (for LED display)
//  io_wait      out  1       1 while in IO_WAIT (registered)
//  halted       out  1       1 while in HALT (registered)
//  retired_cnt  out  CNT_W   committed instructions, saturating (registered)
// BEHAVIOUR
//  Reset (reset_n=0 at a rising edge): state=IDLE, io_wait=0, halted=0,
//   retired_cnt=0; cpu_en=0 while reset_n=0. Reset overrides every state.
//  States: IDLE=0, RUN=1, PAUSE=2, IO_WAIT=3, HALT=4; codes 5-7 -> IDLE.
//  is_brk = (instruction[31:26]==0 && instruction[5:0]==BRK_FUNC).
//  bp_hit = bp_en && (pc==bp_addr).
//  IDLE: cpu_en=0. go_pulse -> PAUSE if mode_step else RUN.
//  RUN, priority order, evaluated on current instruction:
//   is_brk -> HALT, cpu_en=0; mode_step -> PAUSE, cpu_en=0;
//   bp_hit -> PAUSE, cpu_en=0; io_read -> IO_WAIT, cpu_en=0;
//   else cpu_en=1, stay RUN.
//  PAUSE: cpu_en=0 until go_pulse. On go_pulse: is_brk -> HALT, cpu_en=0;
//   else cpu_en=1 (io_read instr commits directly: one press is step and
//   confirm), next = PAUSE if mode_step else RUN. Breakpoint not checked in
//   PAUSE, so resuming from a breakpoint executes that PC exactly once.
//  IO_WAIT: cpu_en=0, io_wait=1. go_pulse -> cpu_en=1 that cycle (switch
//   value sampled by commit), next = PAUSE if mode_step else RUN.
//  HALT: cpu_en=0, halted=1; go_pulse ignored; only reset exits.
//  go_pulse in RUN is ignored. go_pulse and a stall condition in same RUN
//   cycle: stall wins, pulse dropped (user re-presses).
//  retired_cnt += 1 on every cycle with cpu_en=1; holds at 2^CNT_W-1.
//  io_wait / halted reflect the registered state (asserted the cycle after
//   entry). cpu_en=0 in all states during and after reset until go_pulse.
// STRUCTURE
//  Shared package/header (definitions.v): RUN_* state localparams,
//   BRK_FUNC default, opcode 6'h00 constant.
//  One sub-module: sat_counter (param width, inc, sync active-low reset,
//   saturate) for retired_cnt. FSM and Mealy cpu_en stay in cpu_run_ctrl.
// TESTING
//  1 Reset, mode_step=0, go_pulse, 5 plain ADDs -> state RUN, cpu_en=1 for
//    5 cycles, retired_cnt=5.
//  2 RUN, io_read=1 at pc=0x40 -> cpu_en=0, io_wait=1 next cycle; go_pulse
//    after 10 cycles -> one cpu_en=1 cycle, back to RUN, io_wait=0.
//  3 bp_en=1, bp_addr=0x20 -> cpu_en=0 at pc=0x20, state PAUSE; go_pulse ->
//    cpu_en=1 once at pc=0x20, RUN; no re-trigger at 0x24.
//  4 mode_step=1: each go_pulse -> exactly one cpu_en cycle; 3 pulses ->
//    retired_cnt=3; pulse on io_read instr commits it in one press.
//  5 instruction=32'h0000000D in RUN -> HALT, halted=1; go_pulse x3 ->
//    cpu_en stays 0; reset_n=0 one cycle -> IDLE, counters 0.
//  6 CNT_W=4, run 20 instrs -> retired_cnt=15; reset_n low mid-IO_WAIT ->
//    IDLE, io_wait=0 next cycle.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// Shared definitions for the minisys-32 run/step/halt sequencer:
// state codes, BREAK decode constants and the BREAK decode helper.
package cpu_run_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN_IDLE    = 3'd0,
    RUN_RUN     = 3'd1,
    RUN_PAUSE   = 3'd2,
    RUN_IO_WAIT = 3'd3,
    RUN_HALT    = 3'd4
  } run_state_e;

  localparam logic [5:0] OP_SPECIAL   = 6'h00;
  localparam logic [5:0] BRK_FUNC_DEF = 6'h0D;

  // BREAK is an R-type (opcode 0) instruction whose funct field matches.
  function automatic logic is_brk(input logic [31:0] instr, input logic [5:0] func);
    return (instr[31:26] == OP_SPECIAL) && (instr[5:0] == func);
  endfunction

endpackage

// File: rtl/cpu_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous active-low reset; holds at all-ones.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)                      r_cnt <= '0;
    else if (i_inc && (r_cnt != '1))   r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer: produces the Mealy commit enable cpu_en that gates
// PC update, register write and data memory write of the minisys-32 core.
module cpu_run_ctrl
  import cpu_run_ctrl_pkg::*;
#(
  parameter int         ADDR_W   = 32,
  parameter int         CNT_W    = 32,
  parameter logic [5:0] BRK_FUNC = BRK_FUNC_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go_pulse,
  input  logic              mode_step,
  input  logic [ADDR_W-1:0] pc,
  input  logic [31:0]       instruction,
  input  logic              io_read,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic              cpu_en,
  output logic [2:0]        run_state,
  output logic              io_wait,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  run_state_e r_state;
  logic       r_io_wait;
  logic       r_halted;
  run_state_e w_nxt;
  logic       w_cpu_en;
  logic       w_brk;
  logic       w_bp_hit;
  run_state_e w_resume;

  assign w_brk    = is_brk(instruction, BRK_FUNC);
  assign w_bp_hit = bp_en && (pc == bp_addr);
  assign w_resume = mode_step ? RUN_PAUSE : RUN_RUN;

  // In RUN any stall reason wins over a concurrent go_pulse, which is dropped.
  always_comb begin
    w_cpu_en = 1'b0;
    w_nxt    = RUN_IDLE;
    case (r_state)
      RUN_IDLE: w_nxt = go_pulse ? w_resume : RUN_IDLE;
      RUN_RUN: begin
        if (w_brk)                      w_nxt = RUN_HALT;
        else if (mode_step || w_bp_hit) w_nxt = RUN_PAUSE;
        else if (io_read)               w_nxt = RUN_IO_WAIT;
        else begin
          w_cpu_en = 1'b1;
          w_nxt    = RUN_RUN;
        end
      end
      // Breakpoint is not re-checked here so a resumed PC commits exactly once.
      RUN_PAUSE: begin
        w_nxt = RUN_PAUSE;
        if (go_pulse) begin
          if (w_brk) w_nxt = RUN_HALT;
          else begin
            w_cpu_en = 1'b1;
            w_nxt    = w_resume;
          end
        end
      end
      RUN_IO_WAIT: begin
        w_nxt = RUN_IO_WAIT;
        if (go_pulse) begin
          w_cpu_en = 1'b1;
          w_nxt    = w_resume;
        end
      end
      RUN_HALT: w_nxt = RUN_HALT;
      default:  w_nxt = RUN_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= RUN_IDLE;
      r_io_wait <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_io_wait <= (w_nxt == RUN_IO_WAIT);
      r_halted  <= (w_nxt == RUN_HALT);
    end
  end

  assign cpu_en    = w_cpu_en & reset_n;
  assign run_state = r_state;
  assign io_wait   = r_io_wait;
  assign halted    = r_halted;

  sat_counter #(.W(CNT_W)) u_retired (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_inc   (cpu_en),
    .o_cnt   (retired_cnt)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios, a per-cycle behavioural model
// compare, and literal checks; a 4-bit-counter instance shares the stimulus.
module tb_cpu_run_ctrl;

  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_IOW = 3, S_HALT = 4;
  localparam logic [31:0] ADD_I = 32'h00221820;
  localparam logic [31:0] BRK_I = 32'h0000000D;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        go_pulse = 1'b0;
  logic        mode_step = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] instruction = ADD_I;
  logic        io_read = 1'b0;
  logic        bp_en = 1'b0;
  logic [31:0] bp_addr = 32'h0;

  logic        cpu_en, io_wait, halted;
  logic [2:0]  run_state;
  logic [31:0] retired_cnt;
  logic        cpu_en4, io_wait4, halted4;
  logic [2:0]  run_state4;
  logic [3:0]  retired_cnt4;

  cpu_run_ctrl u_dut (
    .clock(clock), .reset_n(reset_n), .go_pulse(go_pulse), .mode_step(mode_step),
    .pc(pc), .instruction(instruction), .io_read(io_read), .bp_en(bp_en),
    .bp_addr(bp_addr), .cpu_en(cpu_en), .run_state(run_state), .io_wait(io_wait),
    .halted(halted), .retired_cnt(retired_cnt)
  );

  cpu_run_ctrl #(.CNT_W(4)) u_dut4 (
    .clock(clock), .reset_n(reset_n), .go_pulse(go_pulse), .mode_step(mode_step),
    .pc(pc), .instruction(instruction), .io_read(io_read), .bp_en(bp_en),
    .bp_addr(bp_addr), .cpu_en(cpu_en4), .run_state(run_state4), .io_wait(io_wait4),
    .halted(halted4), .retired_cnt(retired_cnt4)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: behavioural run state, retired counts for both widths.
  int          m_st = S_IDLE;
  logic [31:0] m_cnt = '0;
  logic [3:0]  m_cnt4 = '0;
  bit          m_valid = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Run-state rules written directly from the behaviour description.
  function automatic void rule(input int st, output bit en, output int nx);
    bit brk, bp;
    brk = (instruction[31:26] == 6'h00) && (instruction[5:0] == 6'h0D);
    bp  = bp_en && (pc == bp_addr);
    en = 0;
    nx = st;
    if (st == S_IDLE) begin
      if (go_pulse) nx = mode_step ? S_PAUSE : S_RUN;
    end else if (st == S_RUN) begin
      if (brk)                  nx = S_HALT;
      else if (mode_step || bp) nx = S_PAUSE;
      else if (io_read)         nx = S_IOW;
      else                      en = 1;
    end else if (st == S_PAUSE || st == S_IOW) begin
      if (go_pulse) begin
        if (st == S_PAUSE && brk) nx = S_HALT;
        else begin
          en = 1;
          nx = mode_step ? S_PAUSE : S_RUN;
        end
      end
    end else if (st != S_HALT) begin
      nx = S_IDLE;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; go_pulse = 1'b0; io_read = 1'b0; instruction = ADD_I;
    tick(1);
    reset_n = 1'b1;
  endtask

  task automatic pulse();
    go_pulse = 1'b1;
    tick(1);
    go_pulse = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        bit en; int nx;
        @(posedge clock);
        if (!reset_n) begin
          m_st = S_IDLE; m_cnt = '0; m_cnt4 = '0; m_valid = 1;
        end else if (m_valid) begin
          rule(m_st, en, nx);
          if (en) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 1;
          end
          m_st = nx;
        end
      end
      forever begin
        bit en; int nx;
        @(negedge clock);
        if (m_valid) begin
          rule(m_st, en, nx);
          chk("model cpu_en", {63'd0, cpu_en}, {63'd0, en & reset_n});
          chk("model run_state", {61'd0, run_state}, 64'(m_st));
          chk("model io_wait", {63'd0, io_wait}, {63'd0, m_st == S_IOW});
          chk("model halted", {63'd0, halted}, {63'd0, m_st == S_HALT});
          chk("model retired_cnt", {32'd0, retired_cnt}, {32'd0, m_cnt});
          chk("model retired_cnt4", {60'd0, retired_cnt4}, {60'd0, m_cnt4});
          chk("model cpu_en4", {63'd0, cpu_en4}, {63'd0, cpu_en});
          chk("model run_state4", {61'd0, run_state4}, {61'd0, run_state});
          chk("model io_wait4", {63'd0, io_wait4}, {63'd0, io_wait});
          chk("model halted4", {63'd0, halted4}, {63'd0, halted});
        end
      end
    join_none

    // Reset state
    tick(2);
    chk("rst state", {61'd0, run_state}, 64'd0);
    chk("rst cpu_en", {63'd0, cpu_en}, 64'd0);
    chk("rst count", {32'd0, retired_cnt}, 64'd0);

    // 1: free run of five ADDs
    reset_n = 1'b1; pc = 32'h0;
    pulse();
    chk("t1 state", {61'd0, run_state}, 64'd1);
    tick(5);
    chk("t1 count", {32'd0, retired_cnt}, 64'd5);

    // 2: IO wait at 0x40, confirm after ten cycles
    do_reset();
    pulse();
    pc = 32'h40; io_read = 1'b1;
    #1 chk("t2 stall en", {63'd0, cpu_en}, 64'd0);
    tick(1);
    chk("t2 io_wait", {63'd0, io_wait}, 64'd1);
    tick(10);
    go_pulse = 1'b1;
    #1 chk("t2 confirm en", {63'd0, cpu_en}, 64'd1);
    tick(1);
    go_pulse = 1'b0; io_read = 1'b0;
    #1 chk("t2 back run", {61'd0, run_state}, 64'd1);
    chk("t2 io_wait clr", {63'd0, io_wait}, 64'd0);
    tick(2);

    // 3: breakpoint at 0x20, resume executes it once
    do_reset();
    bp_en = 1'b1; bp_addr = 32'h20; pc = 32'h1C;
    pulse();
    tick(2);
    pc = 32'h20;
    #1 chk("t3 bp en", {63'd0, cpu_en}, 64'd0);
    tick(1);
    chk("t3 pause", {61'd0, run_state}, 64'd2);
    go_pulse = 1'b1;
    #1 chk("t3 resume en", {63'd0, cpu_en}, 64'd1);
    tick(1);
    go_pulse = 1'b0; pc = 32'h24;
    #1 chk("t3 run 0x24", {61'd0, run_state}, 64'd1);
    chk("t3 en 0x24", {63'd0, cpu_en}, 64'd1);
    tick(3);
    bp_en = 1'b0;

    // 4: single step, three presses then an IO instruction in one press
    do_reset();
    mode_step = 1'b1;
    pulse();
    for (int i = 0; i < 3; i++) begin
      pulse();
      tick(2);
    end
    chk("t4 count", {32'd0, retired_cnt}, 64'd3);
    io_read = 1'b1; go_pulse = 1'b1;
    #1 chk("t4 io en", {63'd0, cpu_en}, 64'd1);
    tick(1);
    go_pulse = 1'b0; io_read = 1'b0;
    #1 chk("t4 io count", {32'd0, retired_cnt}, 64'd4);
    chk("t4 pause", {61'd0, run_state}, 64'd2);
    mode_step = 1'b0;

    // 5: BREAK halts; presses ignored; reset exits
    do_reset();
    pulse();
    tick(2);
    instruction = BRK_I;
    #1 chk("t5 brk en", {63'd0, cpu_en}, 64'd0);
    tick(2);
    chk("t5 halted", {63'd0, halted}, 64'd1);
    chk("t5 state", {61'd0, run_state}, 64'd4);
    for (int i = 0; i < 3; i++) begin
      go_pulse = 1'b1;
      #1 chk("t5 go ignored", {63'd0, cpu_en}, 64'd0);
      tick(1);
      go_pulse = 1'b0;
      tick(1);
    end
    reset_n = 1'b0;
    #1 chk("t5 rst en", {63'd0, cpu_en}, 64'd0);
    tick(1);
    reset_n = 1'b1; instruction = ADD_I;
    #1 chk("t5 idle", {61'd0, run_state}, 64'd0);
    chk("t5 cnt clr", {32'd0, retired_cnt}, 64'd0);
    chk("t5 halt clr", {63'd0, halted}, 64'd0);

    // 6: 4-bit counter saturates; reset out of IO_WAIT
    do_reset();
    pulse();
    tick(20);
    chk("t6 sat", {60'd0, retired_cnt4}, 64'd15);
    chk("t6 wide", {32'd0, retired_cnt}, 64'd20);
    io_read = 1'b1;
    tick(1);
    chk("t6 io_wait", {63'd0, io_wait}, 64'd1);
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1; io_read = 1'b0;
    #1 chk("t6 io_wait clr", {63'd0, io_wait}, 64'd0);
    chk("t6 idle", {61'd0, run_state}, 64'd0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
